fsm: RTL and testbench

// - Overlapping sequence detector on a 4-bit symbol stream, one symbol sampled per clock.
// - Target sequence: 1,0,2,2,1,0 (decimal symbol values).
// - y pulses high for one cycle each time the sequence completes.
// - Small control leaf used by any block that flags this symbol pattern on a 4-bit lane.

---
 rtl/fsm_pkg.sv | 21 ++
 rtl/fsm.sv | 53 +++++
 tb/tb_fsm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared definitions for the 1,0,2,2,1,0 symbol sequence detector.
//   state_e  - 3-bit state encoding S0..S5 (6 and 7 unused)
//   SYM_*    - the only symbol values that take part in the pattern
package fsm_pkg;

    // Each state records how much of the pattern has been seen so far:
    // S0 nothing, S1 "1", S2 "1,0", S3 "1,0,2", S4 "1,0,2,2", S5 "1,0,2,2,1".
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_e;

    localparam logic [3:0] SYM_ZERO = 4'd0;
    localparam logic [3:0] SYM_ONE  = 4'd1;
    localparam logic [3:0] SYM_TWO  = 4'd2;

endpackage

// File: rtl/fsm.sv
// fsm: overlapping detector for the symbol sequence 1,0,2,2,1,0 on a 4-bit lane.
//   clk   in  1  rising-edge clock
//   in    in  4  input symbol, one per clock
//   y     out 1  registered one-cycle pulse on the edge that samples the final 0
//   reset in  1  synchronous active-high reset (x/z count as deasserted)
module fsm
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] in,
    output logic       y,
    input  logic       reset
);

    // Declaration initialisers give a clean power-up state without a reset.
    state_e state_q = S0;
    state_e state_d;
    logic   y_q = 1'b0;
    logic   y_d;

    // A stray 1 always restarts the match at S1; a completed match keeps the
    // trailing "1,0" so overlapping occurrences are caught.
    always_comb begin
        state_d = S0;
        y_d     = 1'b0;
        case (state_q)
            S0: state_d = (in == SYM_ONE) ? S1 : S0;
            S1: state_d = (in == SYM_ZERO) ? S2 : (in == SYM_ONE) ? S1 : S0;
            S2: state_d = (in == SYM_TWO) ? S3 : (in == SYM_ONE) ? S1 : S0;
            S3: state_d = (in == SYM_TWO) ? S4 : (in == SYM_ONE) ? S1 : S0;
            S4: state_d = (in == SYM_ONE) ? S5 : S0;
            S5: begin
                state_d = (in == SYM_ZERO) ? S2 : (in == SYM_ONE) ? S1 : S0;
                y_d     = (in == SYM_ZERO);
            end
            default: state_d = S0;
        endcase
    end

    // An x/z reset takes the else branch, so only reset==1 clears the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_fsm.sv
// tb_fsm: directed self-checking bench for the fsm sequence detector,
// with a window-matching reference model compared on every half-period.
module tb_fsm;

    logic       clk = 1'b0;
    logic [3:0] in_s = 4'd3;
    logic       reset_s = 1'b0;
    logic       y;

    int n_cmp = 0;
    int n_bad = 0;

    fsm dut (
        .clk  (clk),
        .in   (in_s),
        .y    (y),
        .reset(reset_s)
    );

    always #5 clk = ~clk;

    // Reference model: y is 1 after an edge when the last six symbols sampled
    // since the most recent reset spell 1,0,2,2,1,0.
    logic [3:0] hist [6];
    int         seen = 0;
    logic       y_model = 1'b0;
    logic [3:0] pat [6] = '{4'd1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd0};

    always @(posedge clk) begin
        if (reset_s === 1'b1) begin
            seen = 0;
            y_model = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) hist[i] = hist[i + 1];
            hist[5] = in_s;
            seen = seen + 1;
            y_model = (seen >= 6);
            for (int i = 0; i < 6; i++) if (hist[i] !== pat[i]) y_model = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        n_cmp++;
        if (y !== y_model) begin
            n_bad++;
            $display("FAIL model_rise t=%0t y=%b expected=%b", $time, y, y_model);
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (y !== y_model) begin
            n_bad++;
            $display("FAIL model_fall t=%0t y=%b expected=%b", $time, y, y_model);
        end
    end

    task automatic push(input logic [3:0] v, input logic r);
        @(negedge clk);
        in_s = v;
        reset_s = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup;
        #1;
        n_cmp++;
        if (y !== 1'b0) begin
            n_bad++;
            $display("FAIL powerup_y y=%b expected=0", y);
        end
        push(4'd3, 1'b0);
        n_cmp++;
        if (y !== 1'b0) begin
            n_bad++;
            $display("FAIL powerup_first_edge y=%b expected=0", y);
        end
    endtask

    task automatic test_reset;
        push(4'd1, 1'b1);
        n_cmp++;
        if (y !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_edge1 y=%b expected=0", y);
        end
        push(4'd1, 1'b1);
        n_cmp++;
        if (y !== 1'b0 || dut.state_q !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_edge2 y=%b state=%0d expected y=0 state=0", y, dut.state_q);
        end
        push(4'd0, 1'b0);
        n_cmp++;
        if (y !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release y=%b expected=0", y);
        end
    endtask

    task automatic test_stream;
        logic [3:0] s [20] = '{4'd7, 4'd5, 4'd1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd0, 4'd2, 4'd2,
                               4'd1, 4'd0, 4'd3, 4'd9, 4'd2, 4'd1, 4'd0, 4'd2, 4'd2, 4'd8};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 20; i++) begin
                push(s[i], 1'b0);
                n_cmp++;
                if (y !== ((i == 7) || (i == 11))) begin
                    n_bad++;
                    $display("FAIL stream pass=%0d idx=%0d y=%b expected=%b",
                             p, i, y, (i == 7) || (i == 11));
                end
            end
        end
    endtask

    task automatic test_repeat_ones;
        logic [3:0] s [8] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 8; i++) begin
            push(s[i], 1'b0);
            n_cmp++;
            if (y !== (i == 7)) begin
                n_bad++;
                $display("FAIL repeat_ones idx=%0d y=%b expected=%b", i, y, i == 7);
            end
        end
    endtask

    task automatic test_breaks;
        logic [3:0] s [20] = '{4'd1, 4'd0, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0,
                               4'd1, 4'd0, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0,
                               4'd1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 20; i++) begin
            push(s[i], 1'b0);
            n_cmp++;
            if (y !== (i == 19)) begin
                n_bad++;
                $display("FAIL breaks idx=%0d y=%b expected=%b", i, y, i == 19);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] pre [5] = '{4'd1, 4'd0, 4'd2, 4'd2, 4'd1};
        logic [3:0] post [11] = '{4'd0, 4'd2, 4'd2, 4'd1, 4'd0,
                                  4'd1, 4'd0, 4'd2, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 5; i++) push(pre[i], 1'b0);
        push(4'd0, 1'b1);
        n_cmp++;
        if (y !== 1'b0 || dut.state_q !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_reset y=%b state=%0d expected y=0 state=0", y, dut.state_q);
        end
        for (int i = 0; i < 11; i++) begin
            push(post[i], 1'b0);
            n_cmp++;
            if (y !== (i == 10)) begin
                n_bad++;
                $display("FAIL after_reset idx=%0d y=%b expected=%b", i, y, i == 10);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_powerup();
        test_reset();
        test_stream();
        test_repeat_ones();
        test_breaks();
        test_mid_reset();
        push(4'd3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
